game_display_arbiter: RTL and testbench

Shares the single 4-digit seven-segment display and 16-LED bank between several game/menu requesters (menu, classic, infinity, ...). Grants exactly one owner at a time. Enforces a minimum ownership time. Inserts a blanking gap on every owner change. Drives the registered 16-bit digit word that feeds seg7decimal, and the LED bus.

---
 rtl/game_disp_pkg.sv | 23 ++
 rtl/game_disp_pick.sv | 38 +++
 rtl/game_display_arbiter.sv | 176 +++++++++++++++++
 tb/tb_game_display_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_disp_pkg.sv
// Shared definitions for the game display arbiter.
//   ST_IDLE / ST_OWN / ST_BLANK : arbiter state encoding
//   DISP_W                      : width of one digit word / LED pattern
//   idx_w(n)                    : width of an index into n requesters
//   cnt_w(m)                    : width of a counter that must hold 0..m
package game_disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam int DISP_W = 16;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A bound of 0 would give a zero-width counter, so keep at least one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/game_disp_pick.sv
// Combinational requester selector.
//   req     : request vector
//   start   : index the search begins at (used only when rr_mode is high)
//   rr_mode : 0 = fixed priority from index 0, 1 = circular search from start
//   valid   : some request bit is set
//   sel     : chosen index (0 when valid is low)
module game_disp_pick
    import game_disp_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    input  logic               rr_mode,
    output logic               valid,
    output logic [IW-1:0]      sel
);

    int base;
    int idx;

    always_comb begin
        valid = 1'b0;
        sel   = '0;
        idx   = 0;
        base  = rr_mode ? int'(start) : 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/game_display_arbiter.sv
// Arbitrates one 4-digit display and 16-LED bank between NUM_REQ requesters.
// One owner at a time, minimum ownership of MIN_HOLD cycles before it can be
// displaced, BLANK_CYCLES of all-zero output between owners.
//   clk, clr        : clock, synchronous active-high reset
//   req             : level requests, index 0 highest priority
//   seg_in, led_in  : per-requester digit word / LED pattern, 16 bits each
//   grant, owner    : one-hot grant and owner index (0 when no owner)
//   busy            : high while owning or blanking
//   seg_data, led   : registered display data of the owner
// Build option GAME_DISP_RR_EN: round-robin selection, owners yield to any
// other requester after MIN_HOLD instead of being preempted by priority.
//
// state    | meaning
// ST_IDLE  | no owner, outputs zero
// ST_OWN   | owner granted, its data forwarded with one cycle of lag
// ST_BLANK | gap between owners, outputs zero, req re-sampled on last cycle
module game_display_arbiter
    import game_disp_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int MIN_HOLD     = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [DISP_W*NUM_REQ-1:0]   seg_in,
    input  logic [DISP_W*NUM_REQ-1:0]   led_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   owner,
    output logic                        busy,
    output logic [DISP_W-1:0]           seg_data,
    output logic [DISP_W-1:0]           led
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int HW = cnt_w(MIN_HOLD);
    localparam int BW = cnt_w(BLANK_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [DISP_W-1:0]  seg_q, seg_d;
    logic [DISP_W-1:0]  led_q, led_d;

    logic               pick_valid;
    logic [IW-1:0]      pick_sel;
    logic [IW-1:0]      pick_start;
    logic               rr_mode;
    logic               hold_done;
    logic               release_req;
    logic               leave_early;

`ifdef GAME_DISP_RR_EN
    logic [IW-1:0]      last_q, last_d;
    assign rr_mode    = 1'b1;
    assign pick_start = (last_q == IW'(NUM_REQ - 1)) ? '0 : last_q + IW'(1);
    // Any other requester makes a settled owner yield.
    assign leave_early = hold_done && (|(req & ~grant_q));
`else
    assign rr_mode    = 1'b0;
    assign pick_start = '0;
    // grant_q - 1 on a one-hot vector masks exactly the higher-priority bits.
    assign leave_early = hold_done && (|(req & (grant_q - NUM_REQ'(1))));
`endif

    assign hold_done   = (hold_q == HW'(MIN_HOLD));
    assign release_req = !req[owner_q];

    game_disp_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .start   (pick_start),
        .rr_mode (rr_mode),
        .valid   (pick_valid),
        .sel     (pick_sel)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            blank_q <= '0;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            seg_q   <= '0;
            led_q   <= '0;
`ifdef GAME_DISP_RR_EN
            last_q  <= IW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            blank_q <= blank_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
            led_q   <= led_d;
`ifdef GAME_DISP_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        blank_d = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_OWN;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (release_req || leave_early) begin
                    state_d = ST_BLANK;
                    blank_d = '0;
                end else if (!hold_done) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_BLANK: begin
                if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    if (pick_valid) begin
                        state_d = ST_OWN;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        owner_d = '0;
        seg_d   = '0;
        led_d   = '0;
        busy_d  = (state_d != ST_IDLE);
`ifdef GAME_DISP_RR_EN
        last_d  = last_q;
`endif
        if (state_d == ST_OWN) begin
            if (state_q != ST_OWN) begin
                // New grant: data stays zero until the next edge.
                grant_d = NUM_REQ'(1) << pick_sel;
                owner_d = pick_sel;
`ifdef GAME_DISP_RR_EN
                last_d  = pick_sel;
`endif
            end else begin
                grant_d = grant_q;
                owner_d = owner_q;
                seg_d   = seg_in[int'(owner_q)*DISP_W +: DISP_W];
                led_d   = led_in[int'(owner_q)*DISP_W +: DISP_W];
            end
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign seg_data = seg_q;
    assign led      = led_q;

endmodule

// File: tb/tb_game_display_arbiter.sv
// Bench for game_display_arbiter: two instances (MIN_HOLD 4 and 0) share the
// same stimulus and are compared every cycle against an ownership model.
module tb_game_display_arbiter;

    localparam int NR = 3;
    localparam int BLANK = 2;
    localparam int HOLD_LIM [2] = '{4, 0};

    logic        clk;
    logic        clr;
    logic [2:0]  req;
    logic [47:0] seg_in;
    logic [47:0] led_in;

    logic [2:0]  grant_w [2];
    logic [1:0]  owner_w [2];
    logic        busy_w  [2];
    logic [15:0] seg_w   [2];
    logic [15:0] led_w   [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_owner < 0 means no owner; m_gap > 0 means blank cycles remain.
    int          m_owner [2];
    int          m_held  [2];
    int          m_gap   [2];
    int          m_last  [2];
    logic [2:0]  e_grant [2];
    logic [1:0]  e_owner [2];
    logic        e_busy  [2];
    logic [15:0] e_seg   [2];
    logic [15:0] e_led   [2];

    game_display_arbiter #(.NUM_REQ(NR), .MIN_HOLD(4), .BLANK_CYCLES(BLANK)) u_dut (
        .clk(clk), .clr(clr), .req(req), .seg_in(seg_in), .led_in(led_in),
        .grant(grant_w[0]), .owner(owner_w[0]), .busy(busy_w[0]),
        .seg_data(seg_w[0]), .led(led_w[0])
    );

    game_display_arbiter #(.NUM_REQ(NR), .MIN_HOLD(0), .BLANK_CYCLES(BLANK)) u_dut_h0 (
        .clk(clk), .clr(clr), .req(req), .seg_in(seg_in), .led_in(led_in),
        .grant(grant_w[1]), .owner(owner_w[1]), .busy(busy_w[1]),
        .seg_data(seg_w[1]), .led(led_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int i, input logic [2:0] r);
`ifdef GAME_DISP_RR_EN
        for (int k = 1; k <= NR; k++) begin
            int c = (m_last[i] + k) % NR;
            if (r[c]) return c;
        end
`else
        for (int c = 0; c < NR; c++)
            if (r[c]) return c;
`endif
        return -1;
    endfunction

    task automatic set_zero(input int i, input logic busy_v);
        e_grant[i] = 3'b000;
        e_owner[i] = 2'd0;
        e_busy[i]  = busy_v;
        e_seg[i]   = 16'h0;
        e_led[i]   = 16'h0;
    endtask

    task automatic model_try_grant(input int i);
        int p = pick(i, req);
        if (p >= 0) begin
            m_owner[i] = p;
            m_last[i]  = p;
            m_held[i]  = 0;
            set_zero(i, 1'b1);
            e_grant[i] = 3'(1 << p);
            e_owner[i] = 2'(p);
        end else begin
            set_zero(i, 1'b0);
        end
    endtask

    task automatic model_step(input int i);
        logic leave;
        logic [2:0] mine;
        if (clr) begin
            m_owner[i] = -1;
            m_gap[i]   = 0;
            m_last[i]  = NR - 1;
            set_zero(i, 1'b0);
        end else if (m_owner[i] >= 0) begin
            mine = 3'(1 << m_owner[i]);
`ifdef GAME_DISP_RR_EN
            leave = ((req & mine) == 0) ||
                    (m_held[i] >= HOLD_LIM[i] && (req & ~mine) != 0);
`else
            leave = ((req & mine) == 0) ||
                    (m_held[i] >= HOLD_LIM[i] && (req & (mine - 3'd1)) != 0);
`endif
            if (leave) begin
                m_owner[i] = -1;
                m_gap[i]   = BLANK;
                set_zero(i, 1'b1);
            end else begin
                e_seg[i] = seg_in[16*m_owner[i] +: 16];
                e_led[i] = led_in[16*m_owner[i] +: 16];
                m_held[i]++;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0) model_try_grant(i);
        end else begin
            model_try_grant(i);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("grant%0d", i), 32'(grant_w[i]), 32'(e_grant[i]));
            check_val($sformatf("owner%0d", i), 32'(owner_w[i]), 32'(e_owner[i]));
            check_val($sformatf("busy%0d", i),  32'(busy_w[i]),  32'(e_busy[i]));
            check_val($sformatf("seg%0d", i),   32'(seg_w[i]),   32'(e_seg[i]));
            check_val($sformatf("led%0d", i),   32'(led_w[i]),   32'(e_led[i]));
            check_val($sformatf("onehot%0d", i), 32'($countones(grant_w[i]) <= 1), 32'd1);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_held[i] = 0; m_gap[i] = 0; m_last[i] = NR - 1;
            set_zero(i, 1'b0);
        end
        clr    = 1'b1;
        req    = 3'b111;
        seg_in = {16'hABCD, 16'h5678, 16'h1234};
        led_in = {16'h00F0, 16'h0F00, 16'hF000};
        @(negedge clk);

        // Reset with all requests high, then first grant and one-cycle data lag.
        run(2);
        check_val("rst_grant", 32'(grant_w[0]), 32'd0);
        check_val("rst_seg",   32'(seg_w[0]),   32'd0);
        clr = 1'b0;
        cycle();
        check_val("first_grant", 32'(grant_w[0]), 32'b001);
        check_val("first_seg_lag", 32'(seg_w[0]), 32'd0);
        cycle();
        check_val("first_seg", 32'(seg_w[0]), 32'h1234);

        // Hand over to owner 2, then release into blank and idle.
        req = 3'b100;
        run(6);
        req = 3'b000;
        run(5);
        check_val("idle_busy", 32'(busy_w[0]), 32'd0);

        // Preempt of owner 2 by requester 0 raised one cycle after grant.
        req = 3'b100;
        run(2);
        req = 3'b101;
        run(12);

        // Lower-priority requests never displace owner 0.
        req = 3'b111;
        for (int k = 0; k < 50; k++) begin
            seg_in = {$urandom(), 16'($urandom())};
            led_in = {$urandom(), 16'($urandom())};
            cycle();
        end

        // Blank re-sample: owner 1 releases, req changes during the gap.
        req = 3'b000;
        run(4);
        req = 3'b010;
        run(4);
        req = 3'b000;
        cycle();
        req = 3'b100;
        cycle();
        req = 3'b110;
        cycle();
        run(3);
        req = 3'b000;
        cycle();
        req = 3'b100;
        cycle();
        req = 3'b000;
        run(4);

        // Constant full request load (round-robin rotation when enabled).
        req = 3'b111;
        run(30);

        // Randomised traffic with occasional mid-transaction resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b = $urandom_range(0, 2);
                req[b] = ~req[b];
            end
            seg_in[31:0]  = $urandom();
            seg_in[47:32] = 16'($urandom());
            led_in[31:0]  = $urandom();
            led_in[47:32] = 16'($urandom());
            clr = ($urandom_range(0, 149) == 0);
            cycle();
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
